poly_envelope_gen: RTL

POLY_ENVELOPE_GEN -- requirements
Module: poly_envelope_gen

---
 rtl/poly_envelope_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/poly_envelope_gen.sv
// Time-multiplexed ADSR envelope generator. Each sample_tick starts one sweep that updates
// each voice in turn. All voices share one datapath, and each voice keeps its own state.
module poly_envelope_gen #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AMP_BITS   = 8,
  parameter int unsigned ACC_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          gate,
  input  logic [ACC_BITS-1:0]            attack_inc,
  input  logic [ACC_BITS-1:0]            decay_inc,
  input  logic [ACC_BITS-1:0]            release_inc,
  input  logic [AMP_BITS-1:0]            sustain_level,
  input  logic                           clr_overrun,
  output logic [NUM_VOICES*AMP_BITS-1:0] amplitude,
  output logic [NUM_VOICES-1:0]          env_active,
  output logic                           busy,
  output logic                           amp_valid,
  output logic                           overrun
);

  localparam int unsigned SlotW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_VOICES - 1);
  localparam logic [ACC_BITS-1:0] LvlMax = {ACC_BITS{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } voice_state_e;

  voice_state_e          st_q  [NUM_VOICES];
  logic [ACC_BITS-1:0]   lvl_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] prev_gate_q;

  logic             busy_q;
  logic             amp_valid_q;
  logic             overrun_q, overrun_d;
  logic [SlotW-1:0] slot_q;

  voice_state_e        cur_st, nxt_st;
  logic [ACC_BITS-1:0] cur_lvl, nxt_lvl;
  logic [ACC_BITS-1:0] sus_lvl;
  logic [ACC_BITS:0]   att_sum, dec_diff;
  logic                cur_gate, rise;

  assign sus_lvl = ACC_BITS'(sustain_level) << (ACC_BITS - AMP_BITS);

  // Update datapath for the voice currently selected by slot_q.
  always_comb begin
    cur_st   = st_q[slot_q];
    cur_lvl  = lvl_q[slot_q];
    cur_gate = gate[slot_q];
    rise     = cur_gate & ~prev_gate_q[slot_q];
    att_sum  = {1'b0, cur_lvl} + {1'b0, attack_inc};
    dec_diff = {1'b0, cur_lvl} - {1'b0, decay_inc};
    nxt_st   = cur_st;
    nxt_lvl  = cur_lvl;

    unique case (cur_st)
      StIdle: begin
        nxt_lvl = '0;
        if (rise) nxt_st = StAttack;
      end
      StAttack: begin
        if (!cur_gate) begin
          nxt_st = StRelease;
        end else if (att_sum[ACC_BITS] || (att_sum[ACC_BITS-1:0] == LvlMax)) begin
          nxt_lvl = LvlMax;
          nxt_st  = StDecay;
        end else begin
          nxt_lvl = att_sum[ACC_BITS-1:0];
        end
      end
      StDecay: begin
        if (!cur_gate) begin
          nxt_st = StRelease;
        end else if (dec_diff[ACC_BITS] || (dec_diff[ACC_BITS-1:0] <= sus_lvl)) begin
          // Also pulls a level already below sustain up to it.
          nxt_lvl = sus_lvl;
          nxt_st  = StSustain;
        end else begin
          nxt_lvl = dec_diff[ACC_BITS-1:0];
        end
      end
      StSustain: begin
        if (!cur_gate) begin
          nxt_st = StRelease;
        end else begin
          nxt_lvl = sus_lvl;
        end
      end
      StRelease: begin
        if (rise) begin
          nxt_st = StAttack;
        end else if (cur_lvl <= release_inc) begin
          nxt_lvl = '0;
          nxt_st  = StIdle;
        end else begin
          nxt_lvl = cur_lvl - release_inc;
        end
      end
      default: begin
        nxt_st  = StIdle;
        nxt_lvl = '0;
      end
    endcase
  end

  // A tick arriving mid-sweep is dropped; a drop beats a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (sample_tick && busy_q) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      amp_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      slot_q      <= '0;
      prev_gate_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        st_q[i]  <= StIdle;
        lvl_q[i] <= '0;
      end
    end else begin
      amp_valid_q <= 1'b0;
      overrun_q   <= overrun_d;
      if (busy_q) begin
        st_q[slot_q]        <= nxt_st;
        lvl_q[slot_q]       <= nxt_lvl;
        prev_gate_q[slot_q] <= cur_gate;
        if (slot_q == LastSlot) begin
          busy_q      <= 1'b0;
          amp_valid_q <= 1'b1;
          slot_q      <= '0;
        end else begin
          slot_q <= slot_q + SlotW'(1);
        end
      end else if (sample_tick) begin
        busy_q <= 1'b1;
        slot_q <= '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_out
    assign amplitude[i*AMP_BITS +: AMP_BITS] = lvl_q[i][ACC_BITS-1 -: AMP_BITS];
    assign env_active[i] = (st_q[i] != StIdle);
  end

  assign busy      = busy_q;
  assign amp_valid = amp_valid_q;
  assign overrun   = overrun_q;

endmodule
